// File: rtl/writeback_queue.sv
// Writeback queue: buffers results and drains them in FIFO order into register-file write stage.
// Define WRITEBACK_QUEUE_FORWARD_EN to enable the Q_Rd/Q_Hit/Q_Data forwarding lookup.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [63:0]              In_Data,
    input  logic [4:0]               In_Rd,
    input  logic                     Stall,
    output logic [63:0]              BusW,
    output logic [4:0]               RW,
    output logic                     RegWr,
    output logic [$clog2(DEPTH):0]   Count,
    input  logic [4:0]               Q_Rd,
    output logic                     Q_Hit,
    output logic [63:0]              Q_Data
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [4:0]      XZR  = 5'd31;

    logic [63:0]   data_mem_q [DEPTH];
    logic [4:0]    rd_mem_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          regwr_q,  regwr_d;
    logic [4:0]    rw_q,     rw_d;
    logic [63:0]   busw_q,   busw_d;

    logic accept;
    logic store;
    logic pop;

    // Valid/ready: a result transfers on a rising edge where In_Valid && In_Ready.
    // In_Ready depends only on occupancy, never on a same-cycle pop.
    assign In_Ready = (count_q < FULL);
    assign accept   = In_Valid && In_Ready && !Reset;
    // Writes to register 31 complete the handshake but are never queued.
    assign store    = accept && (In_Rd != XZR);
    assign pop      = (count_q != '0) && !Stall;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        regwr_d  = 1'b0;
        rw_d     = rw_q;
        busw_d   = busw_q;

        if (store) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            regwr_d  = 1'b1;
            rw_d     = rd_mem_q[rd_ptr_q];
            busw_d   = data_mem_q[rd_ptr_q];
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            regwr_q  <= 1'b0;
            rw_q     <= '0;
            busw_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            regwr_q  <= regwr_d;
            rw_q     <= rw_d;
            busw_q   <= busw_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge Clk) begin
        if (store) begin
            data_mem_q[wr_ptr_q] <= In_Data;
            rd_mem_q[wr_ptr_q]   <= In_Rd;
        end
    end

    assign Count = count_q;
    assign RegWr = regwr_q;
    assign RW    = rw_q;
    assign BusW  = busw_q;

`ifdef WRITEBACK_QUEUE_FORWARD_EN
    logic [AW-1:0] fwd_idx;
    logic          fwd_hit;
    logic [63:0]   fwd_data;

    // Scan oldest to youngest so later matches override: output stage first, then queue head..tail.
    always_comb begin
        fwd_idx  = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (Q_Rd != XZR) begin
            if (regwr_q && (rw_q == Q_Rd)) begin
                fwd_hit  = 1'b1;
                fwd_data = busw_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fwd_idx = rd_ptr_q + AW'(i);
                if ((CW'(i) < count_q) && (rd_mem_q[fwd_idx] == Q_Rd)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = data_mem_q[fwd_idx];
                end
            end
        end
    end

    assign Q_Hit  = fwd_hit;
    assign Q_Data = fwd_data;
`else
    logic unused_q_rd;
    assign unused_q_rd = ^Q_Rd;
    assign Q_Hit       = 1'b0;
    assign Q_Data      = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus an in-order scoreboard on the write port.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic        In_Ready;
    logic [63:0] In_Data;
    logic [4:0]  In_Rd;
    logic        Stall;
    logic [63:0] BusW;
    logic [4:0]  RW;
    logic        RegWr;
    logic [2:0]  Count;
    logic [4:0]  Q_Rd;
    logic        Q_Hit;
    logic [63:0] Q_Data;

    int checks = 0;
    int errors = 0;

    logic [68:0] exp_q[$];
    logic [68:0] sb_exp;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .In_Data  (In_Data),
        .In_Rd    (In_Rd),
        .Stall    (Stall),
        .BusW     (BusW),
        .RW       (RW),
        .RegWr    (RegWr),
        .Count    (Count),
        .Q_Rd     (Q_Rd),
        .Q_Hit    (Q_Hit),
        .Q_Data   (Q_Data)
    );

    // Clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every register-file write must match the oldest expected entry
    always @(negedge Clk) begin
        if (RegWr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: RegWr=1 RW=%0d BusW=%h, required no write", RW, BusW);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({RW, BusW} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_order: got RW=%0d BusW=%h, expected RW=%0d BusW=%h",
                             RW, BusW, sb_exp[68:64], sb_exp[63:0]);
                end
            end
            checks++;
            if (RW === 5'd31) begin
                errors++;
                $display("FAIL sb_xzr: got RW=31 with RegWr=1, required RW!=31");
            end
        end
    end

    // Driver: offer one result for one edge; scoreboard entry recorded only if it will be queued
    task automatic push(input logic [4:0] rd, input logic [63:0] data, output logic accepted);
        @(negedge Clk);
        In_Valid = 1'b1;
        In_Rd    = rd;
        In_Data  = data;
        accepted = In_Ready;
        if (accepted && rd != 5'd31 && !Reset) exp_q.push_back({rd, data});
        @(posedge Clk);
        #1;
        In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        Reset    = 1'b1;
        In_Valid = 1'b0;
        In_Data  = '0;
        In_Rd    = '0;
        Stall    = 1'b0;
        Q_Rd     = '0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, expected 0", Count); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL reset_regwr: got %b, expected 0", RegWr); end
        checks++; if (RW !== 5'd0) begin errors++; $display("FAIL reset_rw: got %0d, expected 0", RW); end
        checks++; if (BusW !== 64'd0) begin errors++; $display("FAIL reset_busw: got %h, expected 0", BusW); end
        checks++; if (Q_Hit !== 1'b0) begin errors++; $display("FAIL reset_qhit: got %b, expected 0", Q_Hit); end
        checks++; if (Q_Data !== 64'd0) begin errors++; $display("FAIL reset_qdata: got %h, expected 0", Q_Data); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", In_Ready); end
    endtask

    task automatic test_single();
        logic acc;
        Stall = 1'b0;
        push(5'd5, 64'h1234, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL single_accept: got %b, expected 1", acc); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL single_early: got RegWr=%b, expected 0", RegWr); end
        checks++; if (Count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d, expected 1", Count); end
        @(posedge Clk); #1;
        checks++; if (RegWr !== 1'b1) begin errors++; $display("FAIL single_regwr: got %b, expected 1", RegWr); end
        checks++; if (RW !== 5'd5) begin errors++; $display("FAIL single_rw: got %0d, expected 5", RW); end
        checks++; if (BusW !== 64'h1234) begin errors++; $display("FAIL single_busw: got %h, expected 1234", BusW); end
        @(posedge Clk); #1;
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL single_drop: got %b, expected 0", RegWr); end
        checks++; if (RW !== 5'd5 || BusW !== 64'h1234) begin
            errors++; $display("FAIL single_hold: got RW=%0d BusW=%h, expected 5/1234", RW, BusW);
        end
    endtask

    task automatic test_stall_full();
        logic acc;
        Stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            push(5'(k), {$urandom, $urandom}, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL full_accept%0d: got %b, expected 1", k, acc); end
        end
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, expected 4", Count); end
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", In_Ready); end
        push(5'd9, 64'hDEAD, acc);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_held: got accepted=%b, expected 0", acc); end
        checks++; if (Count !== 3'd4) begin errors++; $display("FAIL full_hold_count: got %0d, expected 4", Count); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL full_stalled: got RegWr=%b, expected 0", RegWr); end
        Stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge Clk); #1;
            checks++; if (RegWr !== 1'b1 || RW !== 5'(k)) begin
                errors++; $display("FAIL full_drain%0d: got RegWr=%b RW=%0d, expected 1/%0d", k, RegWr, RW, k);
            end
        end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d, expected 0", Count); end
        @(posedge Clk); #1;
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL full_idle: got %b, expected 0", RegWr); end
    endtask

    task automatic test_xzr();
        logic acc;
        Stall = 1'b0;
        push(5'd31, 64'hFFFF, acc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL xzr_accept: got %b, expected 1", acc); end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL xzr_count: got %0d, expected 0", Count); end
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL xzr_regwr%0d: got %b, expected 0", c, RegWr); end
        end
    endtask

    task automatic test_forward();
        logic acc;
        Stall = 1'b1;
        push(5'd7, 64'hA, acc);
        push(5'd7, 64'hB, acc);
        Q_Rd = 5'd7;
        #1;
`ifdef WRITEBACK_QUEUE_FORWARD_EN
        checks++; if (Q_Hit !== 1'b1 || Q_Data !== 64'hB) begin
            errors++; $display("FAIL fwd_young: got hit=%b data=%h, expected 1/b", Q_Hit, Q_Data);
        end
        Q_Rd = 5'd8; #1;
        checks++; if (Q_Hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b, expected 0", Q_Hit); end
        Q_Rd = 5'd31; #1;
        checks++; if (Q_Hit !== 1'b0) begin errors++; $display("FAIL fwd_xzr: got %b, expected 0", Q_Hit); end
        Q_Rd  = 5'd7;
        Stall = 1'b0;
        @(posedge Clk); #1;
        checks++; if (RegWr !== 1'b1 || BusW !== 64'hA || Q_Hit !== 1'b1 || Q_Data !== 64'hB) begin
            errors++; $display("FAIL fwd_queue_over_stage: got wr=%b busw=%h hit=%b data=%h, expected 1/a/1/b",
                               RegWr, BusW, Q_Hit, Q_Data);
        end
        @(posedge Clk); #1;
        checks++; if (Count !== 3'd0 || Q_Hit !== 1'b1 || Q_Data !== 64'hB) begin
            errors++; $display("FAIL fwd_stage: got count=%0d hit=%b data=%h, expected 0/1/b", Count, Q_Hit, Q_Data);
        end
        @(posedge Clk); #1;
        checks++; if (Q_Hit !== 1'b0) begin errors++; $display("FAIL fwd_gone: got %b, expected 0", Q_Hit); end
`else
        checks++; if (Q_Hit !== 1'b0 || Q_Data !== 64'd0) begin
            errors++; $display("FAIL fwd_tied: got hit=%b data=%h, expected 0/0", Q_Hit, Q_Data);
        end
        Stall = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL fwd_drain: got %0d, expected 0", Count); end
`endif
    endtask

    task automatic test_reset_midstream();
        logic acc;
        Stall = 1'b1;
        push(5'd10, 64'h10, acc);
        push(5'd11, 64'h11, acc);
        push(5'd12, 64'h12, acc);
        checks++; if (Count !== 3'd3) begin errors++; $display("FAIL mid_count: got %0d, expected 3", Count); end
        Reset    = 1'b1;
        In_Valid = 1'b1;
        In_Rd    = 5'd3;
        In_Data  = 64'h33;
        @(posedge Clk); #1;
        Reset    = 1'b0;
        In_Valid = 1'b0;
        exp_q.delete();
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL mid_count_clr: got %0d, expected 0", Count); end
        checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL mid_regwr: got %b, expected 0", RegWr); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, expected 1", In_Ready); end
        Stall = 1'b0;
        push(5'd12, 64'hC0FFEE, acc);
        @(posedge Clk); #1;
        checks++; if (RegWr !== 1'b1 || RW !== 5'd12 || BusW !== 64'hC0FFEE) begin
            errors++; $display("FAIL mid_after: got wr=%b RW=%0d BusW=%h, expected 1/12/c0ffee", RegWr, RW, BusW);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        Stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(5'($urandom_range(0, 30)), {$urandom, $urandom}, acc);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept%0d: got %b, expected 1", i, acc); end
            checks++; if (Count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d: got %0d, expected 1", i, Count); end
            checks++; if (RegWr !== (i > 0)) begin
                errors++; $display("FAIL b2b_regwr%0d: got %b, expected %b", i, RegWr, (i > 0));
            end
        end
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(negedge Clk);
        @(negedge Clk);
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain: got %0d entries outstanding, expected 0", exp_q.size());
        end
        checks++; if (Count !== 3'd0) begin errors++; $display("FAIL b2b_empty: got %0d, expected 0", Count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall_full();
        test_xzr();
        test_forward();
        test_reset_midstream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
